// File: rtl/quad_port_memory_requester_if.sv
// Request, response and memory-port bundle for the two-lane quad-port memory requester.
// slave is the requester's view; master is the client plus memory side.
interface quad_port_memory_requester_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
);
    logic [1:0]                 req_valid;
    logic [1:0]                 req_ready;
    logic [1:0]                 req_write;
    logic [1:0][ADDR_WIDTH-1:0] req_addr;
    logic [1:0][DATA_WIDTH-1:0] req_data;
    logic [1:0]                 rsp_valid;
    logic [1:0]                 rsp_ready;
    logic [1:0][DATA_WIDTH-1:0] rsp_data;
    logic [1:0][ADDR_WIDTH-1:0] mem_write_addr;
    logic [1:0]                 mem_wren;
    logic [1:0][DATA_WIDTH-1:0] mem_data;
    logic [1:0]                 mem_rden;
    logic [1:0][ADDR_WIDTH-1:0] mem_read_addr;
    logic [1:0][DATA_WIDTH-1:0] mem_data_out;

    modport slave (
        input  req_valid, req_write, req_addr, req_data, rsp_ready, mem_data_out,
        output req_ready, rsp_valid, rsp_data,
        output mem_write_addr, mem_wren, mem_data, mem_rden, mem_read_addr
    );

    modport master (
        output req_valid, req_write, req_addr, req_data, rsp_ready, mem_data_out,
        input  req_ready, rsp_valid, rsp_data,
        input  mem_write_addr, mem_wren, mem_data, mem_rden, mem_read_addr
    );
endinterface

// File: rtl/quad_port_memory_requester.sv
// Two-lane front end for a 2W/2R memory: request lanes to port strobes, reads back through credit-checked FIFOs.
// Read response READ_LATENCY+1 cycles after accept; reads stall on credit or on a pending same-address write.

// Generic synchronous FIFO; output is the head entry, valid whenever count is non-zero.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_dat,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign pop_dat = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            store[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (!rst)
        !(push && !do_pop && count == CW'(DEPTH)));
endmodule

module quad_port_memory_requester #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 6,
    parameter int READ_LATENCY_0 = 1,
    parameter int READ_LATENCY_1 = 1,
    parameter int WRITE_DELAY_0  = 0,
    parameter int WRITE_DELAY_1  = 0,
    parameter int RSP_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    quad_port_memory_requester_if.slave   bus
);
    localparam int CW = $clog2(RSP_DEPTH + 1);

    if (READ_LATENCY_0 < 1 || READ_LATENCY_0 > 2) begin : g_bad_rl0
        $error("READ_LATENCY_0 must be 1 or 2");
    end
    if (READ_LATENCY_1 < 1 || READ_LATENCY_1 > 2) begin : g_bad_rl1
        $error("READ_LATENCY_1 must be 1 or 2");
    end
    if (WRITE_DELAY_0 < 0 || WRITE_DELAY_1 < 0) begin : g_bad_wd
        $error("WRITE_DELAY_0/1 must be >= 0");
    end
    if (RSP_DEPTH < 2) begin : g_bad_depth
        $error("RSP_DEPTH must be >= 2");
    end

    logic [1:0]                 wr_req;
    logic [1:0]                 wr_ready;
    logic [1:0]                 rd_ready;
    logic [1:0]                 ready;
    logic [1:0]                 accept;
    logic [1:0]                 wr_acc;
    logic [1:0]                 rd_acc;
    logic [1:0]                 credit_ok;
    logic [1:0][1:0]            sb_hit;     // [writing lane][reading lane]
    logic                       addr_eq;
    logic [1:0][CW-1:0]         fifo_cnt;
    logic [1:0][DATA_WIDTH-1:0] fifo_dat;
    logic [1:0]                 rsp_vld;

    assign wr_req  = bus.req_valid & bus.req_write;
    assign addr_eq = (bus.req_addr[0] == bus.req_addr[1]);

    // A lane-1 write competing with a lane-0 read is always accepted (lane 0 is not writing),
    // so the raw lane-1 write request stands in for its accept and avoids a combinational loop.
    always_comb begin
        wr_ready[0] = 1'b1;
        wr_ready[1] = !(wr_req[0] && addr_eq);
        rd_ready[0] = credit_ok[0] && !sb_hit[0][0] && !sb_hit[1][0] && !(wr_req[1] && addr_eq);
        rd_ready[1] = credit_ok[1] && !sb_hit[0][1] && !sb_hit[1][1] && !(wr_req[0] && addr_eq);
        for (int p = 0; p < 2; p++) begin
            ready[p] = rst && (bus.req_write[p] ? wr_ready[p] : rd_ready[p]);
        end
    end

    assign accept = bus.req_valid & ready;
    assign wr_acc = accept & bus.req_write;
    assign rd_acc = accept & ~bus.req_write;

    assign bus.req_ready      = ready;
    assign bus.mem_wren       = wr_acc;
    assign bus.mem_rden       = rd_acc;
    assign bus.mem_write_addr = bus.req_addr;
    assign bus.mem_read_addr  = bus.req_addr;
    assign bus.mem_data       = bus.req_data;
    assign bus.rsp_data       = fifo_dat;
    assign bus.rsp_valid      = rsp_vld;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rsp_vld[p] = rst && (fifo_cnt[p] != '0);
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_lane
        localparam int RL = (p == 0) ? READ_LATENCY_0 : READ_LATENCY_1;
        localparam int WD = (p == 0) ? WRITE_DELAY_0 : WRITE_DELAY_1;

        logic [RL-1:0] rd_pipe;
        logic [1:0]    inflight;

        always_ff @(posedge clk) begin
            if (!rst) begin
                rd_pipe <= '0;
            end else begin
                rd_pipe <= (rd_pipe << 1) | RL'(rd_acc[p]);
            end
        end

        assign inflight     = 2'($countones(rd_pipe));
        assign credit_ok[p] = (int'(fifo_cnt[p]) + int'(inflight)) < RSP_DEPTH;

        sync_fifo #(
            .WIDTH (DATA_WIDTH),
            .DEPTH (RSP_DEPTH)
        ) u_rsp_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (rd_pipe[RL-1]),
            .push_dat (bus.mem_data_out[p]),
            .pop      (rsp_vld[p] && bus.rsp_ready[p]),
            .pop_dat  (fifo_dat[p]),
            .count    (fifo_cnt[p])
        );

        // Ages 1..WD of each accepted write; age 0 is the live request itself.
        if (WD > 0) begin : g_sb
            logic [WD:1]           sb_vld;
            logic [ADDR_WIDTH-1:0] sb_addr [WD:1];
            logic [1:0]            hit;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    sb_vld <= '0;
                end else begin
                    sb_vld[1] <= wr_acc[p];
                    for (int k = 2; k <= WD; k++) begin
                        sb_vld[k] <= sb_vld[k-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                sb_addr[1] <= bus.req_addr[p];
                for (int k = 2; k <= WD; k++) begin
                    sb_addr[k] <= sb_addr[k-1];
                end
            end

            always_comb begin
                hit = '0;
                for (int r = 0; r < 2; r++) begin
                    for (int k = 1; k <= WD; k++) begin
                        if (sb_vld[k] && sb_addr[k] == bus.req_addr[r]) begin
                            hit[r] = 1'b1;
                        end
                    end
                end
            end

            assign sb_hit[p] = hit;
        end else begin : g_no_sb
            assign sb_hit[p] = '0;
        end
    end
endmodule
